// File: rtl/bc_pkg.sv
// Shared constants for the bc job arbiter: FSM encodings, default timeout
// and the round-robin index helper.
package bc_pkg;

  localparam int GID_W       = 3;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ABORT     = 3'd5;

  // Wrap-around slot index used by the round-robin search.
  function automatic int rr_index(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/bc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the slot
// following the last grant.
module rr_pick
  import bc_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] last,
  output logic [GID_W-1:0] winner,
  output logic             any_req
);

  localparam int IW = $clog2(N_REQ);

  logic          found_s;
  logic [IW-1:0] idx_s;

  // Scan all slots in rotated order; the first hit wins.
  always_comb begin
    winner  = {GID_W{1'b0}};
    found_s = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = IW'(rr_index(int'(last), i + 1, N_REQ));
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        winner  = GID_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/bc_arbiter.sv
// Round-robin scheduler sharing one bo/bc datapath-controller pair between
// N_REQ requesters; drives the bc start/flag handshake and returns results.
module bc_arbiter
  import bc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] x_in,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic [W-1:0]       result,
  output logic [GID_W-1:0]   grant_id,
  output logic               busy,
  output logic [W-1:0]       dp_x,
  output logic               dp_start,
  input  logic               dp_flag,
  input  logic [W-1:0]       dp_result
);

  localparam int              IW       = $clog2(N_REQ);
  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(N_REQ - 1);

  logic [2:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [GID_W-1:0] winner_s;
  logic             any_req_s;
  logic [IW-1:0]    gid_s;
  logic [IW-1:0]    win_s;
  logic [N_REQ-1:0] ack_hot_s;
  logic             owner_req_s;
  logic             timeout_s;
  logic [W-1:0]     x_arr_s [N_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .last    (grant_id),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Operand unpacking, owner ack vector and timeout compare.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      x_arr_s[i] = x_in[i*W +: W];
    end
    gid_s            = grant_id[IW-1:0];
    win_s            = winner_s[IW-1:0];
    owner_req_s      = req[gid_s];
    ack_hot_s        = {N_REQ{1'b0}};
    ack_hot_s[gid_s] = owner_req_s;
    timeout_s        = (cnt_r == CNT_LAST);
  end

  // Job FSM; every output is registered to reflect the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      ack      <= {N_REQ{1'b0}};
      err      <= 1'b0;
      result   <= {W{1'b0}};
      grant_id <= LAST_ID;
      busy     <= 1'b0;
      dp_x     <= {W{1'b0}};
      dp_start <= 1'b0;
    end else begin
      ack <= {N_REQ{1'b0}};
      err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r  <= ST_LAUNCH;
            grant_id <= winner_s;
            dp_x     <= x_arr_s[win_s];
            dp_start <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: begin
          state_r <= ST_WAIT_LOW;
          cnt_r   <= {CW{1'b0}};
        end
        // Timeout is checked first here so the count can never wrap into WAIT_HIGH.
        ST_WAIT_LOW: begin
          if (timeout_s) begin
            state_r  <= ST_ABORT;
            result   <= {W{1'b0}};
            err      <= 1'b1;
            ack      <= ack_hot_s;
            dp_start <= 1'b0;
          end else if (!dp_flag) begin
            state_r <= ST_WAIT_HIGH;
            cnt_r   <= cnt_r + CW'(1);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (dp_flag) begin
            state_r  <= ST_DONE;
            ack      <= ack_hot_s;
            dp_start <= 1'b0;
            if (owner_req_s) begin
              result <= dp_result;
            end else begin
              result <= result;
            end
          end else if (timeout_s) begin
            state_r  <= ST_ABORT;
            result   <= {W{1'b0}};
            err      <= 1'b1;
            ack      <= ack_hot_s;
            dp_start <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE, ST_ABORT: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          dp_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
